apb3_s_regfile: RTL and testbench



---
 rtl/apb3_s_regfile.sv | 110 +++++++++++
 tb/tb_apb3_s_regfile.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb3_s_regfile.sv
// APB3 completer serving a bank of 32-bit registers; register 0 is a read-only ID.
// Programmable wait states, byte strobes and PSLVERR on illegal accesses.
module apb3_s_regfile #(
    parameter int                                APB_MS_MX_DATA_WIDTH = 32,
    parameter int                                APB_MS_MX_ADDR_WIDTH = 32,
    parameter int                                NUM_REGS             = 16,
    parameter logic [APB_MS_MX_ADDR_WIDTH-1:0]   BASE_ADDR            = '0,
    parameter logic [APB_MS_MX_DATA_WIDTH-1:0]   ID_VALUE             = 32'hA9B3_0001
) (
    input  logic                                  PCLK,
    input  logic                                  PRESETn,
    input  logic                                  PSELx,
    input  logic                                  PENABLE,
    input  logic                                  PWRITE,
    input  logic [APB_MS_MX_ADDR_WIDTH-1:0]       PADDR,
    input  logic [APB_MS_MX_DATA_WIDTH-1:0]       PWDATA,
    input  logic [APB_MS_MX_DATA_WIDTH/8-1:0]     PSTRB,
    input  logic [3:0]                            cfg_wait,
    output logic                                  PREADY,
    output logic [APB_MS_MX_DATA_WIDTH-1:0]       PRDATA,
    output logic                                  PSLVERR
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = APB_MS_MX_DATA_WIDTH / 8;
    localparam logic [APB_MS_MX_ADDR_WIDTH-1:0] SPAN = APB_MS_MX_ADDR_WIDTH'(4 * NUM_REGS);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [3:0]                        r_cnt;
    logic [APB_MS_MX_ADDR_WIDTH-1:0]   r_addr;
    logic                              r_write;
    logic [APB_MS_MX_DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]                 r_strb;
    logic [APB_MS_MX_DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic [APB_MS_MX_ADDR_WIDTH-1:0]   w_offset;
    logic [IDX_W-1:0]                  w_idx;
    logic                              w_setup;
    logic                              w_done;
    logic                              w_err;
    logic                              w_wr_en;
    logic [APB_MS_MX_DATA_WIDTH-1:0]   w_rd_val;

    assign w_setup  = (r_state == S_IDLE) && PSELx && !PENABLE;
    assign w_done   = (r_state == S_ACCESS) && (r_cnt == 4'd0) && PSELx;

    // Addresses below BASE_ADDR wrap to a large offset, so one compare covers both bounds.
    assign w_offset = r_addr - BASE_ADDR;
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_err    = (w_offset >= SPAN) || (r_addr[1:0] != 2'b00) ||
                      (r_write && (w_idx == '0));
    assign w_wr_en  = w_done && r_write && !w_err;
    assign w_rd_val = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];

    assign PREADY   = w_done;
    assign PSLVERR  = w_done && w_err;
    assign PRDATA   = (w_done && !w_err && !r_write) ? w_rd_val : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_setup) w_state_nxt = S_ACCESS;
            S_ACCESS: if (!PSELx || (r_cnt == 4'd0)) w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt <= '0;
        end else if (w_setup) begin
            r_cnt <= cfg_wait;
        end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Transfer attributes are captured once in setup; the bus may change afterwards.
    always_ff @(posedge PCLK) begin
        if (w_setup) begin
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (r_strb[b]) begin
                    r_regs[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_apb3_s_regfile.sv
// Directed bench for apb3_s_regfile: a transaction-level register model predicts
// every cycle's outputs, and literal pins fix the values the model must produce.
module tb_apb3_s_regfile;
    localparam logic [31:0] ID = 32'hA9B3_0001;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [3:0]  cfg_wait;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    logic        exp_ready, exp_err;
    logic [31:0] exp_rdata;
    logic        pin_on, pin_err;
    logic [31:0] pin_rdata;
    logic [31:0] mreg [16];

    int vectors     = 0;
    int miscompares = 0;

    apb3_s_regfile #(
        .APB_MS_MX_DATA_WIDTH (32),
        .APB_MS_MX_ADDR_WIDTH (32),
        .NUM_REGS             (16),
        .BASE_ADDR            (32'h0000_0000),
        .ID_VALUE             (ID)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .cfg_wait (cfg_wait),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    always @(negedge PCLK) begin
        vectors++;
        if (PREADY !== exp_ready) begin
            miscompares++;
            $display("FAIL pready t=%0t got %0b want %0b", $time, PREADY, exp_ready);
        end
        vectors++;
        if (PRDATA !== exp_rdata) begin
            miscompares++;
            $display("FAIL prdata t=%0t got %08h want %08h", $time, PRDATA, exp_rdata);
        end
        vectors++;
        if (PSLVERR !== exp_err) begin
            miscompares++;
            $display("FAIL pslverr t=%0t got %0b want %0b", $time, PSLVERR, exp_err);
        end
        if (pin_on) begin
            vectors++;
            if (PRDATA !== pin_rdata) begin
                miscompares++;
                $display("FAIL pin_rdata t=%0t got %08h want %08h", $time, PRDATA, pin_rdata);
            end
            vectors++;
            if (PSLVERR !== pin_err) begin
                miscompares++;
                $display("FAIL pin_err t=%0t got %0b want %0b", $time, PSLVERR, pin_err);
            end
        end
    end

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_exp(input logic rdy, input logic [31:0] rd, input logic er);
        exp_ready = rdy;
        exp_rdata = rd;
        exp_err   = er;
    endtask

    task automatic idle(input int n);
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        set_exp(1'b0, '0, 1'b0);
        repeat (n) cyc();
    endtask

    // One APB transfer. abort_at >= 0 drops PSELx in that access cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [3:0] wt, input int abort_at,
                        input logic pon, input logic [31:0] prd, input logic perr);
        logic        err;
        logic [31:0] rexp;
        logic [31:0] mask;
        err  = (addr % 4 != 0) || (addr >= 32'd64) || (wr && addr < 32'd4);
        rexp = (err || wr) ? 32'h0 : ((addr < 32'd4) ? ID : mreg[addr / 4]);

        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = wdata; PSTRB = strb; cfg_wait = wt;
        set_exp(1'b0, '0, 1'b0);
        pin_on = 1'b0;
        cyc();
        PADDR = ~addr; PWDATA = ~wdata; PSTRB = ~strb; PWRITE = ~wr; cfg_wait = ~wt;
        for (int k = 0; k <= int'(wt); k++) begin
            if (k == abort_at) begin
                PSELx = 1'b0; PENABLE = 1'b0;
                set_exp(1'b0, '0, 1'b0);
                cyc();
                return;
            end
            PENABLE = 1'b1;
            if (k == int'(wt)) begin
                set_exp(1'b1, rexp, err);
                pin_on = pon; pin_rdata = prd; pin_err = perr;
            end else begin
                set_exp(1'b0, '0, 1'b0);
            end
            cyc();
        end
        pin_on = 1'b0;
        set_exp(1'b0, '0, 1'b0);
        if (wr && !err) begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            mreg[addr / 4] = (mreg[addr / 4] & ~mask) | (wdata & mask);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [3:0] wt, input logic [31:0] prd, input logic perr);
        xfer(1'b0, addr, 32'h0, 4'h0, wt, -1, 1'b1, prd, perr);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                      input logic [3:0] wt, input logic perr);
        xfer(1'b1, addr, d, s, wt, -1, 1'b1, 32'h0, perr);
    endtask

    initial begin
        PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; cfg_wait = '0;
        pin_on = 1'b0; pin_rdata = '0; pin_err = 1'b0;
        set_exp(1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        repeat (3) cyc();
        PRESETn = 1'b1;
        idle(1);

        rd(32'h00, 4'd0, ID, 1'b0);
        wr(32'h04, 32'hDEAD_BEEF, 4'hF, 4'd0, 1'b0);
        rd(32'h04, 4'd0, 32'hDEAD_BEEF, 1'b0);
        wr(32'h04, 32'h1122_3344, 4'b0101, 4'd0, 1'b0);
        rd(32'h04, 4'd0, 32'hDE22_BE44, 1'b0);
        wr(32'h08, 32'hAAAA_5555, 4'h0, 4'd1, 1'b0);
        rd(32'h08, 4'd5, 32'h0, 1'b0);
        wr(32'h0C, 32'hCAFE_0C0C, 4'hF, 4'd1, 1'b0);
        wr(32'h3C, 32'h0BAD_F00D, 4'hF, 4'd15, 1'b0);
        rd(32'h3C, 4'd2, 32'h0BAD_F00D, 1'b0);

        wr(32'h00, 32'hFFFF_FFFF, 4'hF, 4'd0, 1'b1);
        wr(32'h40, 32'h1234_5678, 4'hF, 4'd0, 1'b1);
        rd(32'h06, 4'd0, 32'h0, 1'b1);
        rd(32'h40, 4'd1, 32'h0, 1'b1);
        rd(32'h00, 4'd0, ID, 1'b0);

        // PENABLE without a preceding setup phase must not start a transfer
        PSELx = 1'b1; PENABLE = 1'b1; PADDR = 32'h04; PWRITE = 1'b0;
        set_exp(1'b0, '0, 1'b0);
        cyc();
        idle(1);

        xfer(1'b1, 32'h0C, 32'h0000_0055, 4'hF, 4'd3, 1, 1'b0, 32'h0, 1'b0);
        rd(32'h0C, 4'd0, 32'hCAFE_0C0C, 1'b0);

        wr(32'h04, 32'h0000_0001, 4'hF, 4'd0, 1'b0);
        wr(32'h08, 32'h0000_0002, 4'hF, 4'd0, 1'b0);
        wr(32'h0C, 32'h0000_0003, 4'hF, 4'd0, 1'b0);
        wr(32'h10, 32'h0000_0004, 4'hF, 4'd0, 1'b0);
        rd(32'h10, 4'd0, 32'h0000_0004, 1'b0);

        // cfg_wait=2 write to 0x14 hit by reset in its second access cycle
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14;
        PWDATA = 32'h7777_7777; PSTRB = 4'hF; cfg_wait = 4'd2;
        set_exp(1'b0, '0, 1'b0);
        cyc();
        PENABLE = 1'b1;
        cyc();
        #2;
        PRESETn = 1'b0;
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        PSELx = 1'b0; PENABLE = 1'b0;
        repeat (2) cyc();
        PRESETn = 1'b1;
        idle(1);

        for (int i = 0; i < 16; i++) begin
            rd(32'(4 * i), 4'd0, (i == 0) ? ID : 32'h0, 1'b0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
